// File: rtl/miriscv_bypass_ctrl.sv
// Decode-stage hazard/bypass controller: tracks E/M/MP destinations and
// produces per-operand forwarding selects plus a load-use/long-latency stall.
package miriscv_decode_pkg;
    localparam int WB_SRC_W = 2;

    localparam logic [WB_SRC_W-1:0] ALU_DATA = 2'd0;
    localparam logic [WB_SRC_W-1:0] MDU_DATA = 2'd1;
    localparam logic [WB_SRC_W-1:0] LSU_DATA = 2'd2;
    localparam logic [WB_SRC_W-1:0] CSR_DATA = 2'd3;

    localparam logic [1:0] NO_BYPASS = 2'd0;
    localparam logic [1:0] BYPASS_E  = 2'd1;
    localparam logic [1:0] BYPASS_M  = 2'd2;
    localparam logic [1:0] BYPASS_MP = 2'd3;
endpackage

module miriscv_bypass_ctrl
    import miriscv_decode_pkg::*;
#(
    parameter int RF_ADDR_W   = 5,
    parameter bit MP_TRACK_EN = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 d_valid_i,
    input  logic [RF_ADDR_W-1:0] d_rs1_addr_i,
    input  logic                 d_rs1_used_i,
    input  logic [RF_ADDR_W-1:0] d_rs2_addr_i,
    input  logic                 d_rs2_used_i,
    input  logic [RF_ADDR_W-1:0] d_rd_addr_i,
    input  logic                 d_rd_we_i,
    input  logic [WB_SRC_W-1:0]  d_wb_src_i,
    input  logic                 advance_i,
    input  logic                 flush_i,
    input  logic                 m_data_ready_i,
    output logic [1:0]           op1_bypass_o,
    output logic [1:0]           op2_bypass_o,
    output logic                 stall_o
);

    typedef struct packed {
        logic                 vld;
        logic [RF_ADDR_W-1:0] rd;
        logic [WB_SRC_W-1:0]  wb_src;
    } entry_t;

    entry_t e_q, m_q, mp_q;
    entry_t e_d, m_d, mp_d;
    entry_t dec_entry;

    logic rs1_hit_e, rs1_hit_m, rs1_hit_mp;
    logic rs2_hit_e, rs2_hit_m, rs2_hit_mp;
    logic rs1_stall, rs2_stall;
    logic issue;

    function automatic logic hit(input entry_t s, input logic [RF_ADDR_W-1:0] rs,
                                 input logic used, input logic valid);
        return s.vld && (s.rd == rs) && (rs != '0) && used && valid;
    endfunction

    function automatic logic [1:0] sel(input logic he, input logic hm, input logic hmp);
        if (he)
            return BYPASS_E;
        else if (hm)
            return BYPASS_M;
        else if (hmp)
            return BYPASS_MP;
        return NO_BYPASS;
    endfunction

    // E can only forward ALU results; M waits for LSU/MDU data to arrive.
    function automatic logic op_stall(input logic he, input logic hm, input entry_t e,
                                      input entry_t m, input logic ready);
        return (he && (e.wb_src != ALU_DATA)) ||
               (!he && hm && ((m.wb_src == LSU_DATA) || (m.wb_src == MDU_DATA)) && !ready);
    endfunction

    always_comb begin
        rs1_hit_e  = hit(e_q,  d_rs1_addr_i, d_rs1_used_i, d_valid_i);
        rs1_hit_m  = hit(m_q,  d_rs1_addr_i, d_rs1_used_i, d_valid_i);
        rs1_hit_mp = hit(mp_q, d_rs1_addr_i, d_rs1_used_i, d_valid_i) && MP_TRACK_EN;
        rs2_hit_e  = hit(e_q,  d_rs2_addr_i, d_rs2_used_i, d_valid_i);
        rs2_hit_m  = hit(m_q,  d_rs2_addr_i, d_rs2_used_i, d_valid_i);
        rs2_hit_mp = hit(mp_q, d_rs2_addr_i, d_rs2_used_i, d_valid_i) && MP_TRACK_EN;

        op1_bypass_o = sel(rs1_hit_e, rs1_hit_m, rs1_hit_mp);
        op2_bypass_o = sel(rs2_hit_e, rs2_hit_m, rs2_hit_mp);

        rs1_stall = op_stall(rs1_hit_e, rs1_hit_m, e_q, m_q, m_data_ready_i);
        rs2_stall = op_stall(rs2_hit_e, rs2_hit_m, e_q, m_q, m_data_ready_i);
        stall_o   = rs1_stall || rs2_stall;
    end

    always_comb begin
        dec_entry.vld    = d_rd_we_i && (d_rd_addr_i != '0);
        dec_entry.rd     = d_rd_addr_i;
        dec_entry.wb_src = d_wb_src_i;
        issue            = d_valid_i && !stall_o && !flush_i;

        e_d  = e_q;
        m_d  = m_q;
        mp_d = mp_q;
        if (advance_i) begin
            mp_d = MP_TRACK_EN ? m_q : '0;
            m_d  = e_q;
            e_d  = issue ? dec_entry : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            e_q  <= '0;
            m_q  <= '0;
            mp_q <= '0;
        end else begin
            e_q  <= e_d;
            m_q  <= m_d;
            mp_q <= mp_d;
        end
    end

endmodule
